// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial shifter, MSB first, with downstream stall.
// Optional even-parity bit after each word when SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             ser_stall,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIALIZER_PARITY_EN
  logic               par_q, par_d;
`endif

  // State, shifter, counter and parity registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, shift/count update and stream outputs; a stall freezes everything
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
`ifdef SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    load_ready = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = rst;
      end
      SHIFT: begin
        ser_out   = shreg_q[WIDTH-1];
        ser_valid = ~ser_stall;
        if (!ser_stall) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d = PAR;
`else
            ser_last   = 1'b1;
            load_ready = rst;
            state_d    = IDLE;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PAR: begin
        ser_out   = par_q;
        ser_valid = ~ser_stall;
        ser_last  = ~ser_stall;
        if (!ser_stall) begin
          load_ready = rst;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accepted word overrides the exit of the word just finishing
    if (load_valid && load_ready) begin
      shreg_d = load_data;
      cnt_d   = CNT_W'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
      par_d   = ^load_data;
`endif
      state_d = SHIFT;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench for bit_serializer (WIDTH=4 and WIDTH=8 instances)
// with a bit-queue reference model; follows SERIALIZER_PARITY_EN when defined.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int WL4 = 4 + P;
  localparam int WL8 = 8 + P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv4, st4, rdy4, so4, sv4, sl4;
  logic [3:0] ld4;
  logic       lv8, st8, rdy8, so8, sv8, sl8;
  logic [7:0] ld8;

  bit_serializer #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4), .load_ready(rdy4),
    .ser_stall(st4), .ser_out(so4), .ser_valid(sv4), .ser_last(sl4));

  bit_serializer #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8), .load_ready(rdy8),
    .ser_stall(st8), .ser_out(so8), .ser_valid(sv8), .ser_last(sl8));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference: queue of bits still owed on the stream (data MSB first, then parity)
  bit q4[$];
  bit q8[$];
  bit acc4, acc8;

  bit o4[0:4095], v4[0:4095], l4[0:4095], r4[0:4095];
  bit o8[0:4095], v8[0:4095], l8[0:4095], r8[0:4095];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Model update at the active edge from the pre-edge inputs
  always @(posedge clk) begin
    bit r;
    cyc++;
    acc4 = 1'b0;
    acc8 = 1'b0;
    if (!rst) begin
      q4.delete();
      q8.delete();
    end else begin
      r = (q4.size() == 0) || (q4.size() == 1 && !st4);
      if (q4.size() != 0 && !st4) void'(q4.pop_front());
      if (r && lv4) begin
        acc4 = 1'b1;
        for (int i = 3; i >= 0; i--) q4.push_back(ld4[i]);
        if (P == 1) q4.push_back(^ld4);
      end
      r = (q8.size() == 0) || (q8.size() == 1 && !st8);
      if (q8.size() != 0 && !st8) void'(q8.pop_front());
      if (r && lv8) begin
        acc8 = 1'b1;
        for (int i = 7; i >= 0; i--) q8.push_back(ld8[i]);
        if (P == 1) q8.push_back(^ld8);
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle; also logs history
  always @(negedge clk) begin
    bit ev, eo, el, er;
    ev = (q4.size() != 0) && !st4;
    eo = (q4.size() != 0) ? q4[0] : 1'b0;
    el = ev && (q4.size() == 1);
    er = rst && ((q4.size() == 0) || (q4.size() == 1 && !st4));
    check("w4_ser_out", so4, eo);
    check("w4_ser_valid", sv4, ev);
    check("w4_ser_last", sl4, el);
    check("w4_load_ready", rdy4, er);
    ev = (q8.size() != 0) && !st8;
    eo = (q8.size() != 0) ? q8[0] : 1'b0;
    el = ev && (q8.size() == 1);
    er = rst && ((q8.size() == 0) || (q8.size() == 1 && !st8));
    check("w8_ser_out", so8, eo);
    check("w8_ser_valid", sv8, ev);
    check("w8_ser_last", sl8, el);
    check("w8_load_ready", rdy8, er);
    o4[cyc] = so4; v4[cyc] = sv4; l4[cyc] = sl4; r4[cyc] = rdy4;
    o8[cyc] = so8; v8[cyc] = sv8; l8[cyc] = sl8; r8[cyc] = rdy8;
  end

  // Pack n logged samples starting at a cycle, earliest sample in the MSB
  function automatic logic [31:0] grab(input int sel, input int kind, input int start, input int n);
    logic [31:0] res;
    bit b;
    res = '0;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      case (kind)
        0: b = (sel == 4) ? o4[start+i] : o8[start+i];
        1: b = (sel == 4) ? v4[start+i] : v8[start+i];
        2: b = (sel == 4) ? l4[start+i] : l8[start+i];
        default: b = (sel == 4) ? r4[start+i] : r8[start+i];
      endcase
      res = {res[30:0], b};
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    int base;
    int idx;
    int cnt;
    bit done;
    logic [7:0]  words [4];
    logic [63:0] spat;
    words[0] = 8'h81; words[1] = 8'h7E; words[2] = 8'h00; words[3] = 8'hFF;
    spat = 64'h9C3A_0F60_C50E_3318;

    rst = 1'b0;
    lv4 = 1'b0; ld4 = '0; st4 = 1'b0;
    lv8 = 1'b0; ld8 = '0; st8 = 1'b0;
    repeat (2) tick();
    check("reset_ready4", r4[1], 0);
    check("reset_valid4", v4[1], 0);
    check("reset_out4", o4[1], 0);
    check("reset_ready8", r8[1], 0);
    rst = 1'b1;
    tick();

    // Basic word 0010; stall asserted while idle must not block the accept
    base = cyc;
    lv4 = 1'b1; ld4 = 4'b0010; st4 = 1'b1;
    tick();
    lv4 = 1'b0; st4 = 1'b0; ld4 = 4'hF;
    repeat (WL4 + 2) tick();
    check("basic_idle_stall_ready", r4[base], 1);
    check("basic_bits", grab(4, 0, base + 1, WL4), (P == 1) ? 32'h05 : 32'h02);
    check("basic_valid", grab(4, 1, base + 1, WL4 + 1), (P == 1) ? 32'h3E : 32'h1E);
    check("basic_last", grab(4, 2, base + 1, WL4 + 1), 32'h2);
    check("basic_idle_out", o4[base + WL4 + 1], 0);

    // Back-to-back 0010 then 1001
    base = cyc;
    lv4 = 1'b1; ld4 = 4'b0010;
    tick();
    ld4 = 4'b1001;
    repeat (WL4) tick();
    lv4 = 1'b0;
    repeat (WL4 + 2) tick();
    check("b2b_bits", grab(4, 0, base + 1, 2 * WL4), (P == 1) ? 32'h0B2 : 32'h29);
    check("b2b_valid", grab(4, 1, base + 1, 2 * WL4 + 1), (P == 1) ? 32'h7FE : 32'h1FE);
    check("b2b_ready", grab(4, 3, base, 2 * WL4 + 1), (P == 1) ? 32'h421 : 32'h111);

    // Stall 3 cycles from the 2nd bit of 1100, with an ignored load offered meanwhile
    base = cyc;
    lv4 = 1'b1; ld4 = 4'b1100;
    tick();
    lv4 = 1'b0;
    tick();
    st4 = 1'b1; lv4 = 1'b1; ld4 = 4'hF;
    repeat (3) tick();
    st4 = 1'b0; lv4 = 1'b0;
    repeat (WL4 + 3) tick();
    check("stall_hold_out", grab(4, 0, base + 2, 3), 32'h7);
    check("stall_hold_valid", grab(4, 1, base + 2, 3), 32'h0);
    check("stall_hold_ready", grab(4, 3, base + 2, 3), 32'h0);
    check("stall_valid_span", grab(4, 1, base + 1, 8 + P), (P == 1) ? 32'h11E : 32'h8E);
    check("stall_out_span", grab(4, 0, base + 1, 7 + P), (P == 1) ? 32'hF8 : 32'h7C);
    check("stall_last", grab(4, 2, base + 1, 7 + P), 32'h1);

    // Reset mid-word on the 8-bit instance
    base = cyc;
    lv8 = 1'b1; ld8 = 8'hA5;
    tick();
    lv8 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("rstmid_first_bits", grab(8, 0, base + 1, 3), 32'h5);
    check("rstmid_out", o8[base + 5], 0);
    check("rstmid_valid", v8[base + 5], 0);
    check("rstmid_last", l8[base + 5], 0);
    check("rstmid_ready_low", r8[base + 5], 0);
    check("rstmid_ready_after", r8[base + 6], 1);

    // Parity pair 0111 then 0011
    base = cyc;
    lv4 = 1'b1; ld4 = 4'b0111;
    tick();
    ld4 = 4'b0011;
    repeat (WL4) tick();
    lv4 = 1'b0;
    repeat (WL4 + 2) tick();
    check("pair_bits", grab(4, 0, base + 1, 2 * WL4), (P == 1) ? 32'h1E6 : 32'h73);
    check("pair_last", grab(4, 2, base + 1, 2 * WL4), (P == 1) ? 32'h21 : 32'h11);

    // Continuous 8-bit stream under a fixed stall pattern
    base = cyc;
    idx = 0;
    done = 1'b0;
    lv8 = 1'b1; ld8 = words[0];
    for (int k = 0; k < 200 && !done; k++) begin
      st8 = spat[k % 64];
      tick();
      if (acc8) idx++;
      if (idx >= 4) lv8 = 1'b0;
      else ld8 = words[idx];
      if (idx >= 4 && q8.size() == 0) done = 1'b1;
    end
    st8 = 1'b0;
    repeat (2) tick();
    check("stream_done", done, 1);
    cnt = 0;
    for (int i = base; i < cyc; i++) cnt += int'(v8[i]);
    check("stream_bit_count", cnt, (P == 1) ? 36 : 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
